dmem_sort_checker: RTL and testbench
====================================

// Module: dmem_sort_checker
// PURPOSE
//  In-system result checker for the insertion-sort workload on single_cycle_mips.
//  Watches the CPU PC. When the PC reaches the halt address, it reads the sorted array
//  back out of data memory through a read port, one word per cycle.
//  It counts ordering violations and mismatches against an expected-value ROM port,
//  then raises sticky pass/fail flags. This lets a sort run be self-checked without hierarchical peeks.
// PARAMETERS
//  END_PC      32'h78    PC value that triggers the scan (the program's self-loop)
//  BASE_ADDR   32'h80    byte address of array element 0 in dmem
//  N           96        number of 32-bit elements to scan (2..511)
//  MAX_CYCLES  25840     cycle budget from reset release to trigger; exceeding it sets slow
// PORTS
//  clk          in   1   system clock, rising edge
//  reset        in   1   asynchronous, active-high reset
//  pc           in   32  current CPU PC
//  clear        in   1   sync re-arm: return to IDLE, zero counters (cycle counter kept)
//  mem_rd_addr  out  32  dmem byte read address = BASE_ADDR + 4*idx (combinational from idx)
//  mem_rd_data  in   32  dmem read data for mem_rd_addr, same cycle (async-read memory)
//  exp_rd_idx   out  9   expected-ROM index = idx
//  exp_rd_data  in   32  expected value for exp_rd_idx, same cycle
//  busy         out  1   1 while in SCAN
//  done         out  1   sticky; scan complete
//  pass_sorted  out  1   done & (err_unsorted==0)
//  pass_exp     out  1   done & (err_exp==0)
//  err_unsorted out  9   count of pairs with a[i] < a[i+1] (unsigned)
//  err_exp      out  9   count of i with a[i] != exp[i]
//  slow         out  1   latched at trigger: cycle count > MAX_CYCLES
// BEHAVIOUR
//  Reset: state=IDLE, idx=0, prev=0, cyc=0. All outputs 0, except mem_rd_addr=BASE_ADDR.
//  cyc is a 32-bit counter, +1 every edge after reset, saturating at 32'hFFFFFFFF.
//  It is not cleared by clear.
//  FSM IDLE -> SCAN -> DONE:
//   IDLE: on an edge with pc==END_PC, go to SCAN with idx=0 and latch slow=(cyc>MAX_CYCLES).
//    pc is sampled only in IDLE.
//   SCAN: on each edge, sample d=mem_rd_data and e=exp_rd_data for the current idx.
//    If d!=e, then err_exp+1.
//    If idx>0 and prev<d (unsigned, descending order required), then err_unsorted+1.
//    Then prev<=d and idx<=idx+1.
//    The edge with idx==N-1 does its compare and then goes to DONE.
//   DONE: done=1 and holds. pc is ignored; the block does not re-trigger while the CPU spins at END_PC.
//  Latency: busy rises 1 edge after trigger. done rises exactly N edges after the trigger edge.
//   pass flags are valid in the same cycle as done.
//  Exactly N-1 adjacent pairs are checked. No read beyond element N-1.
//  Counters saturate at 511 (no wrap).
//  Equal adjacent values are not a violation.
//  clear (any state) takes priority over trigger. It goes to IDLE and zeroes idx/prev/err_*/done/slow.
//   If pc==END_PC is still true, the next edge re-triggers.
//  reset mid-SCAN: immediate async return to reset values. Partial counts are discarded.
//  mem_rd_addr/exp_rd_idx are only meaningful while busy. Memory contents must be stable during SCAN.
//   The CPU is parked at END_PC, so no stores occur.
// TESTING
//  1 Preload dmem words 32..127 with 95..0 (descending), exp ROM identical, pc=END_PC at cycle 100
//    -> done 96 edges after trigger, pass_sorted=1, pass_exp=1, errs=0, slow=0.
//  2 Same, but swap elements 10 and 11 in dmem only
//    -> err_unsorted=1, err_exp=2, pass_sorted=0, pass_exp=0.
//  3 All 96 elements equal 32'h0000DEAD, exp equal
//    -> err_unsorted=0 (ties allowed).
//  4 Array 32'h80000000 followed by 32'h7FFFFFFF...
//    -> no violation (unsigned compare).
//  5 Trigger at cycle 25841 -> slow=1. Trigger at cycle 25840 -> slow=0.
//  6 Assert reset at idx=40, release, then clear; hold pc!=END_PC
//    -> all outputs 0, state IDLE. Then pc=END_PC -> full rescan, done after 96 edges.

Source files
------------

// File: rtl/dmem_sort_checker.sv
// dmem_sort_checker: checks the result of an in-system sort.
// When the CPU reaches its halt PC, the array is read back from data memory one word
// per cycle. The block counts descending-order violations and mismatches against an
// expected-value ROM, then reports sticky pass/fail and slow flags.
module dmem_sort_checker #(
    parameter logic [31:0] END_PC     = 32'h0000_0078,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0080,
    parameter int          N          = 96,
    parameter logic [31:0] MAX_CYCLES = 32'd25840
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        clear,
    output logic [31:0] mem_rd_addr,
    input  logic [31:0] mem_rd_data,
    output logic [8:0]  exp_rd_idx,
    input  logic [31:0] exp_rd_data,
    output logic        busy,
    output logic        done,
    output logic        pass_sorted,
    output logic        pass_exp,
    output logic [8:0]  err_unsorted,
    output logic [8:0]  err_exp,
    output logic        slow
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [8:0]  LAST_IDX = 9'(N - 1);
    localparam logic [8:0]  CNT_MAX  = 9'h1FF;
    localparam logic [31:0] CYC_MAX  = 32'hFFFF_FFFF;

    logic [1:0]  state_q, state_d;
    logic [8:0]  idx_q, idx_d;
    logic [31:0] prev_q, prev_d;
    logic [31:0] cyc_q, cyc_d;
    logic [8:0]  err_unsorted_q, err_unsorted_d;
    logic [8:0]  err_exp_q, err_exp_d;
    logic        done_q, done_d;
    logic        slow_q, slow_d;
    logic        busy_q, busy_d;
    logic        pass_sorted_q, pass_sorted_d;
    logic        pass_exp_q, pass_exp_d;
    logic        mismatch_s;
    logic        unsorted_s;

    // Saturating increment for the 9-bit error counters (never wraps to zero).
    function automatic logic [8:0] sat_inc(input logic [8:0] cnt, input logic inc);
        logic [8:0] res;
        if (inc && (cnt != CNT_MAX)) begin
            res = cnt + 9'd1;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    // Per-element comparisons on the word currently presented by memory and ROM.
    always_comb begin
        mismatch_s = (mem_rd_data != exp_rd_data);
        unsorted_s = (idx_q != 9'd0) && (prev_q < mem_rd_data);
    end

    // Next-state logic: cycle counter, IDLE/SCAN/DONE sequencing and error accounting.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        prev_d         = prev_q;
        err_unsorted_d = err_unsorted_q;
        err_exp_d      = err_exp_q;
        done_d         = done_q;
        slow_d         = slow_q;
        busy_d         = busy_q;
        pass_sorted_d  = pass_sorted_q;
        pass_exp_d     = pass_exp_q;

        // The cycle counter runs freely and is deliberately untouched by clear.
        if (cyc_q != CYC_MAX) begin
            cyc_d = cyc_q + 32'd1;
        end else begin
            cyc_d = cyc_q;
        end

        if (clear) begin
            // Re-arm wins over a trigger on the same edge.
            state_d        = ST_IDLE;
            idx_d          = 9'd0;
            prev_d         = 32'd0;
            err_unsorted_d = 9'd0;
            err_exp_d      = 9'd0;
            done_d         = 1'b0;
            slow_d         = 1'b0;
            busy_d         = 1'b0;
            pass_sorted_d  = 1'b0;
            pass_exp_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pc == END_PC) begin
                        state_d = ST_SCAN;
                        idx_d   = 9'd0;
                        slow_d  = (cyc_q > MAX_CYCLES);
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    err_exp_d      = sat_inc(err_exp_q, mismatch_s);
                    err_unsorted_d = sat_inc(err_unsorted_q, unsorted_s);
                    prev_d         = mem_rd_data;
                    if (idx_q == LAST_IDX) begin
                        // Park the index at 0 so the read port never points past the array.
                        state_d       = ST_DONE;
                        idx_d         = 9'd0;
                        busy_d        = 1'b0;
                        done_d        = 1'b1;
                        pass_sorted_d = (err_unsorted_d == 9'd0);
                        pass_exp_d    = (err_exp_d == 9'd0);
                    end else begin
                        idx_d = idx_q + 9'd1;
                    end
                end
                ST_DONE: begin
                    // Sticky until clear or reset; pc is ignored while the CPU spins.
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            idx_q          <= 9'd0;
            prev_q         <= 32'd0;
            cyc_q          <= 32'd0;
            err_unsorted_q <= 9'd0;
            err_exp_q      <= 9'd0;
            done_q         <= 1'b0;
            slow_q         <= 1'b0;
            busy_q         <= 1'b0;
            pass_sorted_q  <= 1'b0;
            pass_exp_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            prev_q         <= prev_d;
            cyc_q          <= cyc_d;
            err_unsorted_q <= err_unsorted_d;
            err_exp_q      <= err_exp_d;
            done_q         <= done_d;
            slow_q         <= slow_d;
            busy_q         <= busy_d;
            pass_sorted_q  <= pass_sorted_d;
            pass_exp_q     <= pass_exp_d;
        end
    end

    // Output mapping: read addresses follow idx directly, status comes from flops.
    always_comb begin
        mem_rd_addr  = BASE_ADDR + {21'd0, idx_q, 2'b00};
        exp_rd_idx   = idx_q;
        busy         = busy_q;
        done         = done_q;
        pass_sorted  = pass_sorted_q;
        pass_exp     = pass_exp_q;
        err_unsorted = err_unsorted_q;
        err_exp      = err_exp_q;
        slow         = slow_q;
    end

endmodule

// File: tb/tb_dmem_sort_checker.sv
// Directed testbench for dmem_sort_checker with a behavioural dmem and expected ROM.
module tb_dmem_sort_checker;

    localparam int          N      = 96;
    localparam logic [31:0] END_PC = 32'h0000_0078;
    localparam logic [31:0] BASE   = 32'h0000_0080;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        clear;
    logic [31:0] mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic [8:0]  exp_rd_idx;
    logic [31:0] exp_rd_data;
    logic        busy;
    logic        done;
    logic        pass_sorted;
    logic        pass_exp;
    logic [8:0]  err_unsorted;
    logic [8:0]  err_exp;
    logic        slow;

    logic [31:0] dmem    [0:255];
    logic [31:0] exp_rom [0:511];

    int errors;
    int checks;

    dmem_sort_checker dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .clear        (clear),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .exp_rd_idx   (exp_rd_idx),
        .exp_rd_data  (exp_rd_data),
        .busy         (busy),
        .done         (done),
        .pass_sorted  (pass_sorted),
        .pass_exp     (pass_exp),
        .err_unsorted (err_unsorted),
        .err_exp      (err_exp),
        .slow         (slow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous-read memories.
    assign mem_rd_data = dmem[mem_rd_addr[9:2]];
    assign exp_rd_data = exp_rom[exp_rd_idx];

    // Advance n rising edges, returning on the following falling edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear = 1'b0;
        pc    = 32'd0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic load_desc();
        for (int i = 0; i < 256; i++) dmem[i] = 32'd0;
        for (int i = 0; i < 512; i++) exp_rom[i] = 32'd0;
        for (int i = 0; i < N; i++) begin
            dmem[32 + i] = 32'(95 - i);
            exp_rom[i]   = 32'(95 - i);
        end
    endtask

    // Trigger after c edges from now, follow the scan and check the final flags.
    task automatic scan_and_check(input string name, input int c, input logic [8:0] eu,
                                  input logic [8:0] ee, input logic eslow);
        int bad_addr;
        int bad_early;
        bad_addr  = 0;
        bad_early = 0;
        step(c);
        pc = END_PC;
        step(1);
        for (int i = 0; i < N; i++) begin
            if (exp_rd_idx !== 9'(i) || mem_rd_addr !== BASE + 32'(4 * i)) bad_addr++;
            if (done !== 1'b0 || busy !== 1'b1) bad_early++;
            step(1);
        end
        checks++; if (bad_addr !== 0) begin errors++; $display("FAIL %s addr_seq: bad=%0d want 0", name, bad_addr); end
        checks++; if (bad_early !== 0) begin errors++; $display("FAIL %s busy_window: bad=%0d want 0", name, bad_early); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s done: got %b want 1", name, done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_end: got %b want 0", name, busy); end
        checks++; if (err_unsorted !== eu) begin errors++; $display("FAIL %s err_unsorted: got %0d want %0d", name, err_unsorted, eu); end
        checks++; if (err_exp !== ee) begin errors++; $display("FAIL %s err_exp: got %0d want %0d", name, err_exp, ee); end
        checks++; if (pass_sorted !== (eu == 9'd0)) begin errors++; $display("FAIL %s pass_sorted: got %b want %b", name, pass_sorted, eu == 9'd0); end
        checks++; if (pass_exp !== (ee == 9'd0)) begin errors++; $display("FAIL %s pass_exp: got %b want %b", name, pass_exp, ee == 9'd0); end
        checks++; if (slow !== eslow) begin errors++; $display("FAIL %s slow: got %b want %b", name, slow, eslow); end
        step(4);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL %s sticky: done=%b busy=%b want 1/0", name, done, busy); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear = 1'b0;
        pc    = 32'd0;
        step(2);
        checks++; if (mem_rd_addr !== BASE) begin errors++; $display("FAIL reset addr: got %h want %h", mem_rd_addr, BASE); end
        checks++; if ({busy, done, pass_sorted, pass_exp, slow} !== 5'b0) begin errors++; $display("FAIL reset flags: got %b want 00000", {busy, done, pass_sorted, pass_exp, slow}); end
        checks++; if (err_unsorted !== 9'd0 || err_exp !== 9'd0 || exp_rd_idx !== 9'd0) begin errors++; $display("FAIL reset counts: got %0d/%0d/%0d want 0", err_unsorted, err_exp, exp_rd_idx); end
        reset = 1'b0;
        step(10);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_trigger: busy=%b want 0", busy); end
    endtask

    task automatic test_sorted();
        do_reset();
        load_desc();
        scan_and_check("sorted", 100, 9'd0, 9'd0, 1'b0);
    endtask

    task automatic test_swap();
        do_reset();
        load_desc();
        dmem[42] = 32'd84;
        dmem[43] = 32'd85;
        scan_and_check("swap", 20, 9'd1, 9'd2, 1'b0);
    endtask

    task automatic test_ties();
        do_reset();
        for (int i = 0; i < N; i++) begin
            dmem[32 + i] = 32'h0000_DEAD;
            exp_rom[i]   = 32'h0000_DEAD;
        end
        scan_and_check("ties", 7, 9'd0, 9'd0, 1'b0);
    endtask

    task automatic test_unsigned();
        do_reset();
        dmem[32]   = 32'h8000_0000;
        exp_rom[0] = 32'h8000_0000;
        for (int i = 1; i < N; i++) begin
            dmem[32 + i] = 32'h7FFF_FFFF - 32'(i - 1);
            exp_rom[i]   = 32'h7FFF_FFFF - 32'(i - 1);
        end
        scan_and_check("unsigned", 3, 9'd0, 9'd0, 1'b0);
    endtask

    task automatic test_slow_boundary();
        do_reset();
        load_desc();
        scan_and_check("slow_at_limit", 25840, 9'd0, 9'd0, 1'b0);
        do_reset();
        scan_and_check("slow_over", 25841, 9'd0, 9'd0, 1'b1);
    endtask

    // Clear while DONE with pc still at END_PC: flags drop, next edge re-triggers, cyc kept.
    task automatic test_clear_retrigger();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        checks++; if ({busy, done, pass_sorted, pass_exp, slow} !== 5'b0) begin errors++; $display("FAIL clear flags: got %b want 00000", {busy, done, pass_sorted, pass_exp, slow}); end
        checks++; if (exp_rd_idx !== 9'd0 || err_unsorted !== 9'd0 || err_exp !== 9'd0) begin errors++; $display("FAIL clear counts: got %0d/%0d/%0d want 0", exp_rd_idx, err_unsorted, err_exp); end
        dmem[50] = 32'd1000;
        scan_and_check("retrigger", 0, 9'd1, 9'd1, 1'b1);
    endtask

    task automatic test_reset_mid_scan();
        do_reset();
        load_desc();
        dmem[42] = 32'd84;
        dmem[43] = 32'd85;
        step(5);
        pc = END_PC;
        step(41);
        checks++; if (exp_rd_idx !== 9'd40 || err_exp !== 9'd2) begin errors++; $display("FAIL midscan progress: idx=%0d err_exp=%0d want 40/2", exp_rd_idx, err_exp); end
        reset = 1'b1;
        pc    = 32'd0;
        #1;
        checks++; if (busy !== 1'b0 || mem_rd_addr !== BASE || err_exp !== 9'd0) begin errors++; $display("FAIL async_reset: busy=%b addr=%h err_exp=%0d want 0/%h/0", busy, mem_rd_addr, err_exp, BASE); end
        step(2);
        reset = 1'b0;
        step(2);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        step(3);
        checks++; if ({busy, done, pass_sorted, pass_exp, slow} !== 5'b0 || err_unsorted !== 9'd0 || err_exp !== 9'd0) begin errors++; $display("FAIL post_reset_idle: flags=%b errs=%0d/%0d want 0", {busy, done, pass_sorted, pass_exp, slow}, err_unsorted, err_exp); end
        scan_and_check("rescan", 0, 9'd1, 9'd2, 1'b0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        clear  = 1'b0;
        pc     = 32'd0;
        load_desc();
        test_reset();
        test_sorted();
        test_swap();
        test_ties();
        test_unsigned();
        test_slow_boundary();
        test_clear_retrigger();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
